// File: rtl/mem_bus_arbiter.sv
// Four-requester memory bus arbiter.
// Optional fixed priority for requester 0, otherwise round-robin. Tenures are capped at
// MAX_HOLD cycles, and every tenure is followed by one dead bus-turnaround cycle. A master
// that is cut off at the cap is locked out until it drops its request.
module mem_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned PRIO0    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       bus_busy,
    output logic       timeout,
    output logic [7:0] hold_cnt
);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] blocked_q, blocked_d;
    logic [3:0] blocked_set;
    logic [1:0] last_winner_q, last_winner_d;
    // Low for the first edge after reset, so that no grant is issued on that edge.
    logic       ready_q;

    logic [3:0] eligible;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       win_found;

    // Winner selection: requester 0 first when PRIO0 is set, else search up from last_winner+1.
    always_comb begin
        eligible  = req & ~blocked_q;
        win_idx   = 2'd0;
        win_found = 1'b0;
        cand      = 2'd0;
        if (PRIO0 != 0 && eligible[0]) begin
            win_idx   = 2'd0;
            win_found = 1'b1;
        end
        for (int i = 1; i <= 4; i++) begin
            cand = last_winner_q + 2'(i);
            if (!win_found && eligible[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // Next-state, tenure counting, timeout and lockout bookkeeping.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gnt_id_d      = gnt_id_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;
        last_winner_d = last_winner_q;
        blocked_set   = 4'b0000;
        unique case (state_q)
            StIdle, StRelease: begin
                gnt_d      = 4'b0000;
                gnt_id_d   = 2'd0;
                hold_cnt_d = 8'd0;
                state_d    = StIdle;
                if (ready_q && win_found) begin
                    state_d       = StGrant;
                    gnt_d         = 4'b0001 << win_idx;
                    gnt_id_d      = win_idx;
                    hold_cnt_d    = 8'd1;
                    last_winner_d = win_idx;
                end
            end
            StGrant: begin
                // A voluntary drop wins over the cap, so it never counts as a timeout.
                if (!req[gnt_id_q]) begin
                    state_d    = StRelease;
                    gnt_d      = 4'b0000;
                    gnt_id_d   = 2'd0;
                    hold_cnt_d = 8'd0;
                end else if (hold_cnt_q >= MaxHold) begin
                    state_d               = StRelease;
                    gnt_d                 = 4'b0000;
                    gnt_id_d              = 2'd0;
                    hold_cnt_d            = 8'd0;
                    timeout_d             = 1'b1;
                    blocked_set[gnt_id_q] = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = StIdle;
                gnt_d      = 4'b0000;
                gnt_id_d   = 2'd0;
                hold_cnt_d = 8'd0;
            end
        endcase
        // A lockout lasts until the first edge that sees the request low.
        blocked_d = (blocked_q & req) | blocked_set;
    end

    // State and output registers; reset clears the grant asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            gnt_q         <= 4'b0000;
            gnt_id_q      <= 2'd0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= 8'd0;
            blocked_q     <= 4'b0000;
            last_winner_q <= 2'd3;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
            blocked_q     <= blocked_d;
            last_winner_q <= last_winner_d;
            ready_q       <= 1'b1;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = gnt_id_q;
    assign bus_busy = |gnt_q;
    assign timeout  = timeout_q;
    assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: three instances cover the default configuration,
// pure round-robin, and a short MAX_HOLD.
module tb_mem_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] id_a, id_b, id_c;
    logic       busy_a, busy_b, busy_c;
    logic       to_a, to_b, to_c;
    logic [7:0] hc_a, hc_b, hc_c;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_arbiter #(.MAX_HOLD(16), .PRIO0(1)) u_dut_a (
        .clk(clk), .reset(rst_n), .req(req_a), .gnt(gnt_a), .gnt_id(id_a),
        .bus_busy(busy_a), .timeout(to_a), .hold_cnt(hc_a)
    );

    mem_bus_arbiter #(.MAX_HOLD(16), .PRIO0(0)) u_dut_b (
        .clk(clk), .reset(rst_n), .req(req_b), .gnt(gnt_b), .gnt_id(id_b),
        .bus_busy(busy_b), .timeout(to_b), .hold_cnt(hc_b)
    );

    mem_bus_arbiter #(.MAX_HOLD(4), .PRIO0(1)) u_dut_c (
        .clk(clk), .reset(rst_n), .req(req_c), .gnt(gnt_c), .gnt_id(id_c),
        .bus_busy(busy_c), .timeout(to_c), .hold_cnt(hc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 4'b0000;
        req_b = 4'b0000;
        req_c = 4'b0000;
        #1;
        check("rst_gnt", 8'(gnt_a), 8'h0);
        check("rst_id", 8'(id_a), 8'h0);
        check("rst_busy", 8'(busy_a), 8'h0);
        check("rst_to", 8'(to_a), 8'h0);
        check("rst_hc", hc_a, 8'h0);
        tick();
        tick();

        // First grant no earlier than the second edge after reset release.
        req_a = 4'b0001;
        rst_n = 1'b1;
        tick();
        check("first_edge_no_gnt", 8'(gnt_a), 8'h0);
        tick();
        check("second_edge_gnt", 8'(gnt_a), 8'h1);
        check("second_edge_hc", hc_a, 8'h1);
        req_a = 4'b0000;
        tick();
        check("rel0_gnt", 8'(gnt_a), 8'h0);
        tick();

        // Single requester 1 for three cycles.
        req_a = 4'b0010;
        tick();
        check("single_gnt", 8'(gnt_a), 8'h2);
        check("single_id", 8'(id_a), 8'h1);
        check("single_busy", 8'(busy_a), 8'h1);
        check("single_hc1", hc_a, 8'h1);
        tick();
        check("single_hc2", hc_a, 8'h2);
        tick();
        check("single_hc3", hc_a, 8'h3);
        req_a = 4'b0000;
        tick();
        check("single_rel_gnt", 8'(gnt_a), 8'h0);
        check("single_rel_busy", 8'(busy_a), 8'h0);
        check("single_rel_hc", hc_a, 8'h0);
        check("single_rel_id", 8'(id_a), 8'h0);
        tick();
        check("single_idle_gnt", 8'(gnt_a), 8'h0);

        // Priority: requester 2 holds, req[0] and req[3] rise, no preemption.
        req_a = 4'b0100;
        tick();
        check("prio_hold2_gnt", 8'(gnt_a), 8'h4);
        req_a = 4'b1101;
        tick();
        check("prio_nopreempt_gnt", 8'(gnt_a), 8'h4);
        check("prio_nopreempt_hc", hc_a, 8'h2);
        tick();
        req_a = 4'b1001;
        tick();
        check("prio_rel_gnt", 8'(gnt_a), 8'h0);
        tick();
        check("prio_req0_wins", 8'(gnt_a), 8'h1);
        check("prio_req0_id", 8'(id_a), 8'h0);
        req_a = 4'b0000;
        tick();
        tick();

        // Round robin, PRIO0=0: order 1,2,3,1 with a dead cycle between tenures.
        req_b = 4'b1110;
        tick();
        check("rr_first_1", 8'(gnt_b), 8'h2);
        tick();
        req_b = 4'b1100;
        tick();
        check("rr_gap1", 8'(gnt_b), 8'h0);
        req_b = 4'b1110;
        tick();
        check("rr_second_2", 8'(gnt_b), 8'h4);
        tick();
        req_b = 4'b1010;
        tick();
        check("rr_gap2", 8'(gnt_b), 8'h0);
        req_b = 4'b1110;
        tick();
        check("rr_third_3", 8'(gnt_b), 8'h8);
        check("rr_third_id", 8'(id_b), 8'h3);
        tick();
        req_b = 4'b0110;
        tick();
        check("rr_gap3", 8'(gnt_b), 8'h0);
        req_b = 4'b1110;
        tick();
        check("rr_fourth_1", 8'(gnt_b), 8'h2);
        req_b = 4'b0000;
        tick();
        tick();

        // Timeout at MAX_HOLD=4 with a pending req[1].
        req_c = 4'b1000;
        tick();
        check("to_gnt3", 8'(gnt_c), 8'h8);
        req_c = 4'b1010;
        tick();
        tick();
        tick();
        check("to_hc4", hc_c, 8'h4);
        check("to_gnt_still3", 8'(gnt_c), 8'h8);
        check("to_no_pulse_yet", 8'(to_c), 8'h0);
        tick();
        check("to_pulse", 8'(to_c), 8'h1);
        check("to_rel_gnt", 8'(gnt_c), 8'h0);
        check("to_rel_hc", hc_c, 8'h0);
        tick();
        check("to_pulse_one_cycle", 8'(to_c), 8'h0);
        check("to_pending1_gnt", 8'(gnt_c), 8'h2);
        req_c = 4'b1000;
        tick();
        tick();
        check("to_blocked_no_regrant", 8'(gnt_c), 8'h0);
        tick();
        check("to_blocked_still", 8'(gnt_c), 8'h0);
        req_c = 4'b0000;
        tick();
        req_c = 4'b1000;
        tick();
        check("to_unblocked_regrant", 8'(gnt_c), 8'h8);

        // Holder drops req on the same edge the cap is reached: normal release.
        tick();
        tick();
        tick();
        check("sim_hc4", hc_c, 8'h4);
        req_c = 4'b0000;
        tick();
        check("sim_no_timeout", 8'(to_c), 8'h0);
        check("sim_rel_gnt", 8'(gnt_c), 8'h0);
        req_c = 4'b1000;
        tick();
        check("sim_not_blocked", 8'(gnt_c), 8'h8);
        req_c = 4'b0000;
        tick();
        tick();

        // Asynchronous reset while requester 2 holds with hold_cnt=5.
        req_a = 4'b0100;
        tick();
        tick();
        tick();
        tick();
        tick();
        check("rstmid_gnt_before", 8'(gnt_a), 8'h4);
        check("rstmid_hc_before", hc_a, 8'h5);
        req_a = 4'b0101;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_gnt", 8'(gnt_a), 8'h0);
        check("rstmid_hc", hc_a, 8'h0);
        check("rstmid_id", 8'(id_a), 8'h0);
        check("rstmid_busy", 8'(busy_a), 8'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstmid_first_edge", 8'(gnt_a), 8'h0);
        tick();
        check("rstmid_req0_first", 8'(gnt_a), 8'h1);
        req_a = 4'b0000;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
